wt_mem_arbiter: RTL and testbench
=================================

Name: wt_mem_arbiter

Overview:
- Parametrised N-client request/return arbiter between write-through L1 cache clients and one memory adapter port.
- Generalises the fixed two-client (I$ ID 0, D$ ID 1) hookup to NumPorts clients.
- Adds round-robin fairness, per-client outstanding-transaction limits and transaction-ID remapping with return routing.
- Adds a drain/idle handshake for fence and flush sequencing.

Parameters:
- NumPorts, 2, number of cache clients (1..8).
- AddrWidth, 64, request address width.
- DataWidth, 64, write and return data width.
- TidWidth, 2, client-local transaction ID width.
- MaxOutstanding, 4, maximum in-flight transactions per client (1..2^TidWidth).
- PortWidth (derived), max(1, $clog2(NumPorts)).
- GTidWidth (derived), TidWidth + PortWidth.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- cli_req_i  in  NumPorts  per-client request valid.
- cli_ack_o  out  NumPorts  per-client request accepted (one cycle).
- cli_addr_i  in  NumPorts*AddrWidth  request address.
- cli_wdata_i  in  NumPorts*DataWidth  write data.
- cli_we_i  in  NumPorts  1 = write, 0 = read.
- cli_tid_i  in  NumPorts*TidWidth  client-local transaction ID.
- cli_rtrn_vld_o  out  NumPorts  return valid, one-hot or zero.
- cli_rtrn_tid_o  out  TidWidth  returned local ID (shared bus).
- cli_rtrn_data_o  out  DataWidth  return data (shared bus).
- mem_req_o  out  1  memory request valid.
- mem_ack_i  in  1  memory accepted request.
- mem_addr_o  out  AddrWidth  forwarded address.
- mem_wdata_o  out  DataWidth  forwarded write data.
- mem_we_o  out  1  forwarded write enable.
- mem_tid_o  out  GTidWidth  global ID = {port index, local tid}.
- mem_rtrn_vld_i  in  1  memory return valid.
- mem_rtrn_tid_i  in  GTidWidth  global ID of the return.
- mem_rtrn_data_i  in  DataWidth  return data.
- drain_i  in  1  block new grants.
- idle_o  out  1  no request pending, nothing outstanding.
- err_o  out  1  sticky: unroutable return seen.

Behaviour:
- Reset (synchronous, rst_i high at a clock edge):
  - RR pointer = 0, lock = 0, all outstanding counters = 0.
  - Return registers cleared, err_o = 0.
  - All outputs 0 in the following cycle, except idle_o = 1.
  - Reset mid-transaction discards all in-flight state; returns arriving after reset are unroutable and set err_o.
- Client handshake:
  - Client holds req and payload stable until it sees ack.
  - cli_ack_o[p] is asserted in the same cycle as mem_ack_i while port p is granted.
- Eligibility: port p is eligible iff cli_req_i[p] && count[p] < MaxOutstanding && !drain_i. The registered count is used; a return in the same cycle does not bypass.
- State machine:
  - IDLE: select the first eligible port starting at the RR pointer, wrapping modulo NumPorts. Set mem_req_o combinationally that cycle and latch grant index g; go to LOCKED unless mem_ack_i is already high that same cycle (zero-wait accept).
  - LOCKED: mem_req_o = 1, payload is muxed from port g, and g is held regardless of other requests or drain_i.
  - On mem_ack_i: ack port g, count[g]++, RR pointer = (g+1) mod NumPorts, go to IDLE.
- mem_tid_o = {g[PortWidth-1:0], cli_tid_i[g]}. Payload outputs are 0 when mem_req_o = 0.
- Return path (registered, 1-cycle latency):
  - On mem_rtrn_vld_i, p = mem_rtrn_tid_i[GTidWidth-1:TidWidth].
  - If p < NumPorts and count[p] > 0: next cycle cli_rtrn_vld_o[p] = 1 with tid and data, and count[p]--.
  - Otherwise drop the return and set err_o (cleared only by reset).
- Counters: simultaneous increment and decrement on the same port leaves the count unchanged. Counters never exceed MaxOutstanding and never go below 0.
- idle_o = !mem_req_o && all counts == 0 && no return registered.
- drain_i does not abort a LOCKED request.

Test Plan:
- Single client: NumPorts=2, port 0 read tid 1 addr 0x1000, mem_ack_i on 2nd cycle -> mem_tid_o=0b001, cli_ack_o=01 in the ack cycle; return gtid 0b001 data 0xDEAD -> cli_rtrn_vld_o=01, tid 1, 0xDEAD one cycle later; idle_o=1 afterwards.
- Fairness: both ports request continuously with immediate acks -> grants alternate 0,1,0,1; neither port is acked twice in a row.
- Limit: MaxOutstanding=2, port 1 issues 3 requests with no returns -> 3rd request is not granted and port 0 is still served; 3rd is granted the cycle after a port-1 return.
- Simultaneous events: return for port 0 in the same cycle as an ack for port 0 at count 1 -> count stays 1; routed return is correct.
- Unroutable return: NumPorts=3, return gtid port field = 3, or port 2 with count 0 -> no cli_rtrn_vld_o, err_o=1 and sticky until rst_i.
- Drain and reset: drain_i raised while LOCKED -> the locked request completes and no further grants occur; idle_o rises after the last return. rst_i mid-LOCKED -> mem_req_o=0 next cycle, counts 0, idle_o=1.

Source files
------------

// File: rtl/wt_mem_arbiter.sv
// wt_mem_arbiter: round-robin arbiter between N write-through cache clients
// and one memory adapter port. It tracks outstanding transactions per client,
// tags each request with a global ID {port, local tid}, routes returns back to
// the owning client, and provides a drain/idle handshake for fences.
module wt_mem_arbiter #(
    parameter int unsigned NumPorts       = 2,
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned TidWidth       = 2,
    parameter int unsigned MaxOutstanding = 4,
    localparam int unsigned PortWidth     = (NumPorts > 1) ? $clog2(NumPorts) : 1,
    localparam int unsigned GTidWidth     = TidWidth + PortWidth
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumPorts-1:0]           cli_req_i,
    output logic [NumPorts-1:0]           cli_ack_o,
    input  logic [NumPorts*AddrWidth-1:0] cli_addr_i,
    input  logic [NumPorts*DataWidth-1:0] cli_wdata_i,
    input  logic [NumPorts-1:0]           cli_we_i,
    input  logic [NumPorts*TidWidth-1:0]  cli_tid_i,
    output logic [NumPorts-1:0]           cli_rtrn_vld_o,
    output logic [TidWidth-1:0]           cli_rtrn_tid_o,
    output logic [DataWidth-1:0]          cli_rtrn_data_o,
    output logic                          mem_req_o,
    input  logic                          mem_ack_i,
    output logic [AddrWidth-1:0]          mem_addr_o,
    output logic [DataWidth-1:0]          mem_wdata_o,
    output logic                          mem_we_o,
    output logic [GTidWidth-1:0]          mem_tid_o,
    input  logic                          mem_rtrn_vld_i,
    input  logic [GTidWidth-1:0]          mem_rtrn_tid_i,
    input  logic [DataWidth-1:0]          mem_rtrn_data_i,
    input  logic                          drain_i,
    output logic                          idle_o,
    output logic                          err_o
);

    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

    state_e                 state_q;
    logic [PortWidth-1:0]   grant_q;
    logic [PortWidth-1:0]   rr_q;
    logic [NumPorts-1:0]    rtrn_vld_q;
    logic [TidWidth-1:0]    rtrn_tid_q;
    logic [DataWidth-1:0]   rtrn_data_q;
    logic                   err_q;

    logic [AddrWidth-1:0]   addr_arr  [NumPorts];
    logic [DataWidth-1:0]   wdata_arr [NumPorts];
    logic [TidWidth-1:0]    tid_arr   [NumPorts];
    logic [NumPorts-1:0]    we_arr;
    logic [NumPorts-1:0]    elig;
    logic [NumPorts-1:0]    ack_vec;
    logic [NumPorts-1:0]    rtrn_hit;
    logic [NumPorts-1:0]    cnt_zero;
    logic [PortWidth-1:0]   sel_idx;
    logic [PortWidth-1:0]   cur_idx;
    logic [PortWidth-1:0]   rtrn_port;
    logic                   sel_found;
    logic                   mem_req;
    logic                   rtrn_bad;
    int unsigned            sel_cand;

    assign rtrn_port = mem_rtrn_tid_i[GTidWidth-1:TidWidth];

    for (genvar gi = 0; gi < NumPorts; gi++) begin : g_port
        logic [CntWidth-1:0] cnt_q;

        assign addr_arr[gi]  = cli_addr_i[gi*AddrWidth +: AddrWidth];
        assign wdata_arr[gi] = cli_wdata_i[gi*DataWidth +: DataWidth];
        assign tid_arr[gi]   = cli_tid_i[gi*TidWidth +: TidWidth];
        assign we_arr[gi]    = cli_we_i[gi];

        // A client competes only while it has credit left and no drain is requested.
        assign elig[gi]     = cli_req_i[gi] && (cnt_q < CntWidth'(MaxOutstanding)) && !drain_i;
        assign ack_vec[gi]  = mem_req && mem_ack_i && (cur_idx == PortWidth'(gi));
        // A return is routable only to a client that actually has something in flight.
        assign rtrn_hit[gi] = mem_rtrn_vld_i && (rtrn_port == PortWidth'(gi)) && (cnt_q != '0);
        assign cnt_zero[gi] = (cnt_q == '0);

        // Outstanding-transaction counter; an accept and a return together cancel out.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else if (ack_vec[gi] && !rtrn_hit[gi]) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (rtrn_hit[gi] && !ack_vec[gi]) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    function automatic logic [PortWidth-1:0] next_port(input logic [PortWidth-1:0] p);
        if (32'(p) == NumPorts - 1) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Round-robin search: first eligible port at or after the RR pointer.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_cand  = 0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            sel_cand = 32'(rr_q) + i;
            if (sel_cand >= NumPorts) begin
                sel_cand = sel_cand - NumPorts;
            end
            if (!sel_found && elig[sel_cand[PortWidth-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = sel_cand[PortWidth-1:0];
            end
        end
    end

    // Once locked, the grant is held until memory accepts, whatever else happens.
    assign cur_idx = (state_q == ST_LOCKED) ? grant_q : sel_idx;
    assign mem_req = (state_q == ST_LOCKED) || sel_found;

    assign mem_req_o   = mem_req;
    assign mem_addr_o  = mem_req ? addr_arr[cur_idx]  : '0;
    assign mem_wdata_o = mem_req ? wdata_arr[cur_idx] : '0;
    assign mem_we_o    = mem_req ? we_arr[cur_idx]    : 1'b0;
    assign mem_tid_o   = mem_req ? {cur_idx, tid_arr[cur_idx]} : '0;
    assign cli_ack_o   = ack_vec;

    // Grant FSM: IDLE picks a port (zero-wait accept stays in IDLE), LOCKED waits for ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_found) begin
                        if (mem_ack_i) begin
                            rr_q <= next_port(sel_idx);
                        end else begin
                            state_q <= ST_LOCKED;
                            grant_q <= sel_idx;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (mem_ack_i) begin
                        rr_q    <= next_port(grant_q);
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rtrn_bad = mem_rtrn_vld_i && (rtrn_hit == '0);

    // Return path: one register stage; unroutable returns are dropped and flagged.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rtrn_vld_q  <= '0;
            rtrn_tid_q  <= '0;
            rtrn_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            rtrn_vld_q <= rtrn_hit;
            if (rtrn_hit != '0) begin
                rtrn_tid_q  <= mem_rtrn_tid_i[TidWidth-1:0];
                rtrn_data_q <= mem_rtrn_data_i;
            end else begin
                rtrn_tid_q  <= '0;
                rtrn_data_q <= '0;
            end
            if (rtrn_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    assign cli_rtrn_vld_o  = rtrn_vld_q;
    assign cli_rtrn_tid_o  = rtrn_tid_q;
    assign cli_rtrn_data_o = rtrn_data_q;
    assign err_o           = err_q;
    assign idle_o          = !mem_req && (&cnt_zero) && (rtrn_vld_q == '0);

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// Testbench for wt_mem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbiter.
module tb_wt_mem_arbiter;

    localparam int NP = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TW = 2;
    localparam int MO = 2;
    localparam int PW = 2;
    localparam int GW = TW + PW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [NP-1:0]    cli_req;
    logic [NP-1:0]    cli_ack;
    logic [NP*AW-1:0] cli_addr;
    logic [NP*DW-1:0] cli_wdata;
    logic [NP-1:0]    cli_we;
    logic [NP*TW-1:0] cli_tid;
    logic [NP-1:0]    cli_rtrn_vld;
    logic [TW-1:0]    cli_rtrn_tid;
    logic [DW-1:0]    cli_rtrn_data;
    logic             mem_req;
    logic             mem_ack;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic             mem_we;
    logic [GW-1:0]    mem_tid;
    logic             mem_rtrn_vld;
    logic [GW-1:0]    mem_rtrn_tid;
    logic [DW-1:0]    mem_rtrn_data;
    logic             drain;
    logic             idle;
    logic             err;

    int vectors     = 0;
    int miscompares = 0;

    wt_mem_arbiter #(
        .NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .TidWidth(TW), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cli_req_i(cli_req), .cli_ack_o(cli_ack), .cli_addr_i(cli_addr),
        .cli_wdata_i(cli_wdata), .cli_we_i(cli_we), .cli_tid_i(cli_tid),
        .cli_rtrn_vld_o(cli_rtrn_vld), .cli_rtrn_tid_o(cli_rtrn_tid), .cli_rtrn_data_o(cli_rtrn_data),
        .mem_req_o(mem_req), .mem_ack_i(mem_ack), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_we_o(mem_we), .mem_tid_o(mem_tid),
        .mem_rtrn_vld_i(mem_rtrn_vld), .mem_rtrn_tid_i(mem_rtrn_tid), .mem_rtrn_data_i(mem_rtrn_data),
        .drain_i(drain), .idle_o(idle), .err_o(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [TW-1:0] t);
        cli_we[p]            = we;
        cli_addr[p*AW +: AW]  = a;
        cli_wdata[p*DW +: DW] = d;
        cli_tid[p*TW +: TW]   = t;
    endtask

    task automatic clear_inputs();
        cli_req       = '0;
        cli_addr      = '0;
        cli_wdata     = '0;
        cli_we        = '0;
        cli_tid       = '0;
        mem_ack       = 1'b0;
        mem_rtrn_vld  = 1'b0;
        mem_rtrn_tid  = '0;
        mem_rtrn_data = '0;
        drain         = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({mem_req, cli_ack, mem_we, mem_tid, mem_addr, mem_wdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_mem got req=%b ack=%b we=%b tid=%h addr=%h wdata=%h want all 0",
                     mem_req, cli_ack, mem_we, mem_tid, mem_addr, mem_wdata);
        end
        vectors++;
        if ({cli_rtrn_vld, cli_rtrn_tid, cli_rtrn_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_rtrn got vld=%b tid=%h data=%h want 0", cli_rtrn_vld, cli_rtrn_tid, cli_rtrn_data);
        end
        vectors++;
        if ({idle, err} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_flags got idle=%b err=%b want idle=1 err=0", idle, err);
        end
        $display("reset: checked outputs after reset");
    endtask

    task automatic test_single();
        do_reset();
        set_port(0, 1'b0, 32'h1000, 32'h0, 2'd1);
        cli_req = 3'b001;
        @(negedge clk);
        vectors++;
        if ({mem_req, mem_tid, mem_addr, cli_ack} !== {1'b1, 4'b0001, 32'h1000, 3'b000}) begin
            miscompares++;
            $display("FAIL single_req got req=%b tid=%b addr=%h ack=%b want 1 0001 00001000 000",
                     mem_req, mem_tid, mem_addr, cli_ack);
        end
        tick();
        mem_ack = 1'b1;
        @(negedge clk);
        vectors++;
        if ({mem_req, mem_tid, cli_ack} !== {1'b1, 4'b0001, 3'b001}) begin
            miscompares++;
            $display("FAIL single_ack got req=%b tid=%b ack=%b want 1 0001 001", mem_req, mem_tid, cli_ack);
        end
        tick();
        mem_ack = 1'b0;
        cli_req = '0;
        mem_rtrn_vld = 1'b1;
        mem_rtrn_tid = 4'b0001;
        mem_rtrn_data = 32'hDEAD;
        @(negedge clk);
        vectors++;
        if ({mem_req, mem_addr, idle, cli_rtrn_vld} !== {1'b0, 32'h0, 1'b0, 3'b000}) begin
            miscompares++;
            $display("FAIL single_wait got req=%b addr=%h idle=%b rvld=%b want 0 0 0 000",
                     mem_req, mem_addr, idle, cli_rtrn_vld);
        end
        tick();
        mem_rtrn_vld = 1'b0;
        @(negedge clk);
        vectors++;
        if ({cli_rtrn_vld, cli_rtrn_tid, cli_rtrn_data, idle} !== {3'b001, 2'd1, 32'hDEAD, 1'b0}) begin
            miscompares++;
            $display("FAIL single_rtrn got vld=%b tid=%0d data=%h idle=%b want 001 1 0000dead 0",
                     cli_rtrn_vld, cli_rtrn_tid, cli_rtrn_data, idle);
        end
        tick();
        @(negedge clk);
        vectors++;
        if ({cli_rtrn_vld, idle, err} !== {3'b000, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL single_idle got vld=%b idle=%b err=%b want 000 1 0", cli_rtrn_vld, idle, err);
        end
        $display("single: port0 read tid1 issued and returned");
    endtask

    task automatic test_fairness();
        do_reset();
        set_port(0, 1'b0, 32'hA0, 32'h0, 2'd2);
        set_port(1, 1'b1, 32'hB0, 32'h55, 2'd3);
        cli_req = 3'b011;
        mem_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            int p;
            int q;
            logic [NP-1:0] exp_ack;
            logic [NP-1:0] exp_rv;
            logic [GW-1:0] exp_tid;
            p = i % 2;
            q = 1 - p;
            mem_rtrn_vld = (i > 0);
            mem_rtrn_tid = {2'(q), (q == 0) ? 2'd2 : 2'd3};
            exp_ack = '0;
            exp_ack[p] = 1'b1;
            exp_rv = '0;
            if (i >= 2) exp_rv[p] = 1'b1;
            exp_tid = {2'(p), (p == 0) ? 2'd2 : 2'd3};
            @(negedge clk);
            vectors++;
            if ({cli_ack, mem_tid, cli_rtrn_vld} !== {exp_ack, exp_tid, exp_rv}) begin
                miscompares++;
                $display("FAIL fair_cycle%0d got ack=%b tid=%b rvld=%b want ack=%b tid=%b rvld=%b",
                         i, cli_ack, mem_tid, cli_rtrn_vld, exp_ack, exp_tid, exp_rv);
            end
            $display("fairness: cycle %0d grant port %0d", i, p);
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_limit();
        do_reset();
        mem_ack = 1'b1;
        set_port(1, 1'b0, 32'h200, 32'h0, 2'd0);
        cli_req = 3'b010;
        @(negedge clk);
        vectors++;
        if ({cli_ack, mem_tid} !== {3'b010, 4'b0100}) begin
            miscompares++;
            $display("FAIL limit_first got ack=%b tid=%b want 010 0100", cli_ack, mem_tid);
        end
        tick();
        set_port(1, 1'b0, 32'h204, 32'h0, 2'd1);
        @(negedge clk);
        vectors++;
        if ({cli_ack, mem_tid} !== {3'b010, 4'b0101}) begin
            miscompares++;
            $display("FAIL limit_second got ack=%b tid=%b want 010 0101", cli_ack, mem_tid);
        end
        tick();
        set_port(1, 1'b0, 32'h208, 32'h0, 2'd2);
        set_port(0, 1'b0, 32'h300, 32'h0, 2'd3);
        cli_req = 3'b011;
        @(negedge clk);
        vectors++;
        if ({cli_ack, mem_tid} !== {3'b001, 4'b0011}) begin
            miscompares++;
            $display("FAIL limit_port0 got ack=%b tid=%b want 001 0011", cli_ack, mem_tid);
        end
        tick();
        cli_req = 3'b010;
        @(negedge clk);
        vectors++;
        if ({mem_req, cli_ack} !== {1'b0, 3'b000}) begin
            miscompares++;
            $display("FAIL limit_block got req=%b ack=%b want 0 000", mem_req, cli_ack);
        end
        tick();
        mem_rtrn_vld = 1'b1;
        mem_rtrn_tid = 4'b0100;
        mem_rtrn_data = 32'h77;
        @(negedge clk);
        vectors++;
        if ({mem_req, cli_ack} !== {1'b0, 3'b000}) begin
            miscompares++;
            $display("FAIL limit_nobypass got req=%b ack=%b want 0 000", mem_req, cli_ack);
        end
        tick();
        mem_rtrn_vld = 1'b0;
        @(negedge clk);
        vectors++;
        if ({mem_req, cli_ack, mem_tid, cli_rtrn_vld, cli_rtrn_data} !== {1'b1, 3'b010, 4'b0110, 3'b010, 32'h77}) begin
            miscompares++;
            $display("FAIL limit_resume got req=%b ack=%b tid=%b rvld=%b rdata=%h want 1 010 0110 010 77",
                     mem_req, cli_ack, mem_tid, cli_rtrn_vld, cli_rtrn_data);
        end
        $display("limit: third port1 request held until a port1 return");
        tick();
        clear_inputs();
    endtask

    task automatic test_simultaneous();
        do_reset();
        mem_ack = 1'b1;
        set_port(0, 1'b1, 32'h40, 32'h1, 2'd0);
        cli_req = 3'b001;
        tick();
        set_port(0, 1'b0, 32'h44, 32'h0, 2'd1);
        mem_rtrn_vld = 1'b1;
        mem_rtrn_tid = 4'b0000;
        mem_rtrn_data = 32'h1234;
        @(negedge clk);
        vectors++;
        if (cli_ack !== 3'b001) begin
            miscompares++;
            $display("FAIL simul_ack got ack=%b want 001", cli_ack);
        end
        tick();
        cli_req = '0;
        mem_ack = 1'b0;
        mem_rtrn_tid = 4'b0001;
        mem_rtrn_data = 32'h5678;
        @(negedge clk);
        vectors++;
        if ({cli_rtrn_vld, cli_rtrn_tid, cli_rtrn_data, idle} !== {3'b001, 2'd0, 32'h1234, 1'b0}) begin
            miscompares++;
            $display("FAIL simul_rtrn1 got vld=%b tid=%0d data=%h idle=%b want 001 0 1234 0",
                     cli_rtrn_vld, cli_rtrn_tid, cli_rtrn_data, idle);
        end
        tick();
        mem_rtrn_vld = 1'b0;
        @(negedge clk);
        vectors++;
        if ({cli_rtrn_vld, cli_rtrn_tid, cli_rtrn_data, err} !== {3'b001, 2'd1, 32'h5678, 1'b0}) begin
            miscompares++;
            $display("FAIL simul_rtrn2 got vld=%b tid=%0d data=%h err=%b want 001 1 5678 0",
                     cli_rtrn_vld, cli_rtrn_tid, cli_rtrn_data, err);
        end
        tick();
        @(negedge clk);
        vectors++;
        if ({idle, err} !== 2'b10) begin
            miscompares++;
            $display("FAIL simul_count got idle=%b err=%b want 1 0", idle, err);
        end
        $display("simultaneous: ack and return on port0 kept count at 1");
    endtask

    task automatic test_unroutable();
        do_reset();
        mem_rtrn_vld = 1'b1;
        mem_rtrn_tid = 4'b1101;
        mem_rtrn_data = 32'h99;
        tick();
        mem_rtrn_vld = 1'b0;
        @(negedge clk);
        vectors++;
        if ({cli_rtrn_vld, err} !== {3'b000, 1'b1}) begin
            miscompares++;
            $display("FAIL unrt_port3 got vld=%b err=%b want 000 1", cli_rtrn_vld, err);
        end
        tick();
        tick();
        @(negedge clk);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL unrt_sticky got err=%b want 1", err);
        end
        do_reset();
        @(negedge clk);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL unrt_clear got err=%b want 0", err);
        end
        mem_rtrn_vld = 1'b1;
        mem_rtrn_tid = 4'b1000;
        tick();
        mem_rtrn_vld = 1'b0;
        @(negedge clk);
        vectors++;
        if ({cli_rtrn_vld, idle, err} !== {3'b000, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL unrt_cnt0 got vld=%b idle=%b err=%b want 000 1 1", cli_rtrn_vld, idle, err);
        end
        repeat (3) tick();
        @(negedge clk);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL unrt_sticky2 got err=%b want 1", err);
        end
        do_reset();
        @(negedge clk);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL unrt_clear2 got err=%b want 0", err);
        end
        $display("unroutable: port3 and empty port2 returns flagged");
    endtask

    task automatic test_drain();
        do_reset();
        set_port(0, 1'b1, 32'h400, 32'hCAFE, 2'd1);
        cli_req = 3'b001;
        @(negedge clk);
        vectors++;
        if ({mem_req, mem_tid, cli_ack} !== {1'b1, 4'b0001, 3'b000}) begin
            miscompares++;
            $display("FAIL drain_lock got req=%b tid=%b ack=%b want 1 0001 000", mem_req, mem_tid, cli_ack);
        end
        tick();
        drain = 1'b1;
        set_port(1, 1'b0, 32'h500, 32'h0, 2'd2);
        cli_req = 3'b011;
        @(negedge clk);
        vectors++;
        if ({mem_req, mem_tid, mem_addr, mem_wdata, mem_we} !== {1'b1, 4'b0001, 32'h400, 32'hCAFE, 1'b1}) begin
            miscompares++;
            $display("FAIL drain_hold got req=%b tid=%b addr=%h wdata=%h we=%b want 1 0001 400 cafe 1",
                     mem_req, mem_tid, mem_addr, mem_wdata, mem_we);
        end
        tick();
        mem_ack = 1'b1;
        @(negedge clk);
        vectors++;
        if (cli_ack !== 3'b001) begin
            miscompares++;
            $display("FAIL drain_ack got ack=%b want 001", cli_ack);
        end
        tick();
        cli_req = 3'b010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({mem_req, cli_ack, idle} !== {1'b0, 3'b000, 1'b0}) begin
                miscompares++;
                $display("FAIL drain_block%0d got req=%b ack=%b idle=%b want 0 000 0", i, mem_req, cli_ack, idle);
            end
            tick();
        end
        mem_rtrn_vld = 1'b1;
        mem_rtrn_tid = 4'b0001;
        mem_rtrn_data = 32'hBEEF;
        tick();
        mem_rtrn_vld = 1'b0;
        @(negedge clk);
        vectors++;
        if ({cli_rtrn_vld, cli_rtrn_data, idle} !== {3'b001, 32'hBEEF, 1'b0}) begin
            miscompares++;
            $display("FAIL drain_rtrn got vld=%b data=%h idle=%b want 001 beef 0", cli_rtrn_vld, cli_rtrn_data, idle);
        end
        tick();
        @(negedge clk);
        vectors++;
        if ({mem_req, idle} !== 2'b01) begin
            miscompares++;
            $display("FAIL drain_idle got req=%b idle=%b want 0 1", mem_req, idle);
        end
        tick();
        drain = 1'b0;
        @(negedge clk);
        vectors++;
        if ({mem_req, cli_ack, mem_tid, idle} !== {1'b1, 3'b010, 4'b0110, 1'b0}) begin
            miscompares++;
            $display("FAIL drain_release got req=%b ack=%b tid=%b idle=%b want 1 010 0110 0",
                     mem_req, cli_ack, mem_tid, idle);
        end
        $display("drain: locked request completed, idle reached, grants resumed");
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_port(1, 1'b0, 32'h600, 32'h0, 2'd0);
        cli_req = 3'b010;
        mem_ack = 1'b1;
        @(negedge clk);
        vectors++;
        if (cli_ack !== 3'b010) begin
            miscompares++;
            $display("FAIL rmid_ack got ack=%b want 010", cli_ack);
        end
        tick();
        set_port(0, 1'b0, 32'h700, 32'h0, 2'd2);
        cli_req = 3'b001;
        mem_ack = 1'b0;
        tick();
        @(negedge clk);
        vectors++;
        if ({mem_req, mem_tid, idle} !== {1'b1, 4'b0010, 1'b0}) begin
            miscompares++;
            $display("FAIL rmid_locked got req=%b tid=%b idle=%b want 1 0010 0", mem_req, mem_tid, idle);
        end
        do_reset();
        @(negedge clk);
        vectors++;
        if ({mem_req, cli_ack, idle, err} !== {1'b0, 3'b000, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL rmid_after got req=%b ack=%b idle=%b err=%b want 0 000 1 0", mem_req, cli_ack, idle, err);
        end
        mem_rtrn_vld = 1'b1;
        mem_rtrn_tid = 4'b0100;
        tick();
        mem_rtrn_vld = 1'b0;
        @(negedge clk);
        vectors++;
        if ({cli_rtrn_vld, err} !== {3'b000, 1'b1}) begin
            miscompares++;
            $display("FAIL rmid_stale got vld=%b err=%b want 000 1", cli_rtrn_vld, err);
        end
        $display("reset_mid: in-flight state discarded");
    endtask

    task automatic test_random();
        logic [GW-1:0] outst[$];
        bit            pend[NP];
        logic [TW-1:0] ptid[NP];
        logic [AW-1:0] paddr[NP];
        logic [DW-1:0] pwdata[NP];
        logic          pwe[NP];
        int            cnt[NP];
        bit            m_locked;
        int            m_g;
        int            m_rr;
        logic [NP-1:0] exp_rv;
        logic [TW-1:0] exp_rtid;
        logic [DW-1:0] exp_rdata;
        bit            exp_err;
        do_reset();
        m_locked = 0; m_g = 0; m_rr = 0;
        exp_rv = '0; exp_rtid = '0; exp_rdata = '0; exp_err = 0;
        for (int p = 0; p < NP; p++) pend[p] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            int ret_idx;
            bit bogus;
            bit exp_req;
            int exp_port;
            logic [NP-1:0] exp_ack;
            logic [GW-1:0] exp_tid;
            logic [AW-1:0] exp_addr;
            logic [DW-1:0] exp_wdata;
            logic exp_we;
            bit exp_idle;
            for (int p = 0; p < NP; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p]   = 1;
                    ptid[p]   = TW'($urandom);
                    paddr[p]  = $urandom;
                    pwdata[p] = $urandom;
                    pwe[p]    = 1'($urandom);
                    set_port(p, pwe[p], paddr[p], pwdata[p], ptid[p]);
                end
                cli_req[p] = pend[p];
            end
            drain   = ($urandom_range(0, 9) == 0);
            mem_ack = 1'($urandom_range(0, 1));
            ret_idx = -1;
            bogus   = 0;
            if (outst.size() > 0 && $urandom_range(0, 2) == 0) ret_idx = $urandom_range(0, outst.size() - 1);
            else if ($urandom_range(0, 59) == 0) bogus = 1;
            mem_rtrn_vld  = (ret_idx >= 0) || bogus;
            mem_rtrn_tid  = bogus ? {2'b11, 2'($urandom)} : ((ret_idx >= 0) ? outst[ret_idx] : '0);
            mem_rtrn_data = $urandom;

            for (int p = 0; p < NP; p++) cnt[p] = 0;
            foreach (outst[k]) cnt[outst[k][GW-1:TW]]++;
            exp_req = 0;
            exp_port = 0;
            if (m_locked) begin
                exp_req = 1;
                exp_port = m_g;
            end else begin
                for (int i = 0; i < NP; i++) begin
                    int q;
                    q = (m_rr + i) % NP;
                    if (!exp_req && pend[q] && cnt[q] < MO && !drain) begin
                        exp_req = 1;
                        exp_port = q;
                    end
                end
            end
            exp_ack = '0;
            if (exp_req && mem_ack) exp_ack[exp_port] = 1'b1;
            exp_tid   = exp_req ? {2'(exp_port), ptid[exp_port]} : '0;
            exp_addr  = exp_req ? paddr[exp_port] : '0;
            exp_wdata = exp_req ? pwdata[exp_port] : '0;
            exp_we    = exp_req ? pwe[exp_port] : 1'b0;
            exp_idle  = !exp_req && (outst.size() == 0) && (exp_rv == '0);

            @(negedge clk);
            vectors++;
            if ({mem_req, cli_ack, mem_tid, mem_addr, mem_wdata, mem_we} !==
                {exp_req, exp_ack, exp_tid, exp_addr, exp_wdata, exp_we}) begin
                miscompares++;
                $display("FAIL rand_req cyc%0d got req=%b ack=%b tid=%b addr=%h wd=%h we=%b want req=%b ack=%b tid=%b addr=%h wd=%h we=%b",
                         cyc, mem_req, cli_ack, mem_tid, mem_addr, mem_wdata, mem_we,
                         exp_req, exp_ack, exp_tid, exp_addr, exp_wdata, exp_we);
            end
            vectors++;
            if (cli_rtrn_vld !== exp_rv || (exp_rv != '0 && {cli_rtrn_tid, cli_rtrn_data} !== {exp_rtid, exp_rdata})) begin
                miscompares++;
                $display("FAIL rand_rtrn cyc%0d got vld=%b tid=%0d data=%h want vld=%b tid=%0d data=%h",
                         cyc, cli_rtrn_vld, cli_rtrn_tid, cli_rtrn_data, exp_rv, exp_rtid, exp_rdata);
            end
            vectors++;
            if ({idle, err} !== {exp_idle, exp_err}) begin
                miscompares++;
                $display("FAIL rand_flags cyc%0d got idle=%b err=%b want idle=%b err=%b", cyc, idle, err, exp_idle, exp_err);
            end
            if (exp_ack != '0) $display("random: cyc %0d grant port %0d gtid %b", cyc, exp_port, exp_tid);

            if (ret_idx >= 0) begin
                logic [GW-1:0] g;
                g = outst[ret_idx];
                outst.delete(ret_idx);
                exp_rv = '0;
                exp_rv[g[GW-1:TW]] = 1'b1;
                exp_rtid  = g[TW-1:0];
                exp_rdata = mem_rtrn_data;
            end else begin
                exp_rv = '0;
                if (bogus) exp_err = 1;
            end
            if (exp_req && mem_ack) begin
                outst.push_back(exp_tid);
                pend[exp_port] = 0;
                m_rr = (exp_port + 1) % NP;
                m_locked = 0;
            end else if (exp_req && !m_locked) begin
                m_locked = 1;
                m_g = exp_port;
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_fairness();
        test_limit();
        test_simultaneous();
        test_unroutable();
        test_drain();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
